// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants.
// Provides the controller state enum, register-zero index and exit code.
package pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [31:0] SYSCALL_EXIT = 32'd10;

endpackage

// File: rtl/hazard_cmp.sv
// RAW hit detector for one producer stage against the ID instruction.
// In: id_rs/id_rt/id_uses_rs/id_uses_rt, producer rd/reg_write. Out: hit.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] rd,
  input  logic       reg_write,
  output logic       hit
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == rd);
  assign rt_hit = id_uses_rt && (id_rt == rd);

  // $zero is hardwired, so a write to it never produces a dependency
  assign hit = reg_write && (rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_halt_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage core, with perf counters.
// Ports: ID/EX/MEM hazard inputs, go; stall/flush, halted, counters.
// Macro FORWARD_EN: forwarding present, only load-use stalls.
module hazard_halt_ctrl
  import pipe_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = SYSCALL_EXIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch_taken,
  input  logic             ex_syscall,
  input  logic [31:0]      ex_v0,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             go,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   hit_ex;
  logic   data_haz;
  logic   exit_sc;
  logic   stall_ev;
  logic   flush_ev;

  hazard_cmp u_cmp_ex (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .rd         (ex_rd),
    .reg_write  (ex_reg_write),
    .hit        (hit_ex)
  );

`ifdef FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_reg_write};
  // ALU results forward; only a load in EX is too late
  assign data_haz = hit_ex && ex_mem_to_reg;
`else
  logic hit_mem;
  logic unused_ld;

  hazard_cmp u_cmp_mem (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .rd         (mem_rd),
    .reg_write  (mem_reg_write),
    .hit        (hit_mem)
  );

  assign unused_ld = ex_mem_to_reg;
  assign data_haz  = hit_ex || hit_mem;
`endif

  assign exit_sc = ex_syscall && (ex_v0 == HALT_CODE);

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_ev   = 1'b0;
    flush_ev   = 1'b0;
    priority case (1'b1)
      (state == HALT): begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      exit_sc: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_ev   = 1'b1;
      end
      // squashing ID makes any hazard it carries moot
      ex_branch_taken: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_ev   = 1'b1;
      end
      data_haz: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        stall_ev   = 1'b1;
      end
      // jump held under a stall re-presents next cycle
      id_jump: begin
        ifid_flush = 1'b1;
        flush_ev   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + ONE;
          if (exit_sc) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (go) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
      if (stall_ev)
        stall_cnt <= stall_cnt + ONE;
      if (flush_ev)
        flush_cnt <= flush_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_hazard_halt_ctrl.sv
// Self-checking bench for hazard_halt_ctrl (CNT_W=4 to reach wrap).
// Directed scenarios plus random traffic against a rule-level model.
module tb_hazard_halt_ctrl;

  localparam int CW = 4;
  localparam int MOD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
  logic          id_uses_rs, id_uses_rt, id_jump;
  logic          ex_reg_write, ex_mem_to_reg;
  logic          ex_branch_taken, ex_syscall;
  logic [31:0]   ex_v0;
  logic          mem_reg_write, go;
  logic          pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic          halted;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  bit         m_halt;
  int         m_cyc, m_stl, m_fl;
  logic [3:0] exp_o;
  int         exp_kind;
  bit         m_exit;

  hazard_halt_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken),
    .ex_syscall(ex_syscall), .ex_v0(ex_v0),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .go(go),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs from the priority rules; exp_o = {pc,ifs,iff,idf}
  function automatic void model_comb();
    bit rd_ex, rd_mem, hex, hmem, haz;
    rd_ex  = (id_uses_rs && id_rs == ex_rd) ||
             (id_uses_rt && id_rt == ex_rd);
    rd_mem = (id_uses_rs && id_rs == mem_rd) ||
             (id_uses_rt && id_rt == mem_rd);
    hex  = ex_reg_write && ex_rd != 0 && rd_ex;
    hmem = mem_reg_write && mem_rd != 0 && rd_mem;
`ifdef FORWARD_EN
    haz = hex && ex_mem_to_reg;
`else
    haz = hex || hmem;
`endif
    m_exit = ex_syscall && ex_v0 == 32'd10;
    exp_kind = 0;
    if (m_halt) exp_o = 4'b1101;
    else if (m_exit) begin
      exp_o = 4'b1011; exp_kind = 2;
    end else if (ex_branch_taken) begin
      exp_o = 4'b0011; exp_kind = 2;
    end else if (haz) begin
      exp_o = 4'b1101; exp_kind = 1;
    end else if (id_jump) begin
      exp_o = 4'b0010; exp_kind = 2;
    end else exp_o = 4'b0000;
  endfunction

  task automatic clear_inputs();
    rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_branch_taken = 0; ex_syscall = 0; ex_v0 = 0;
    mem_reg_write = 0; go = 0;
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst) begin
      m_halt = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      if (!m_halt) m_cyc = (m_cyc + 1) % MOD;
      if (exp_kind == 1) m_stl = (m_stl + 1) % MOD;
      if (exp_kind == 2) m_fl = (m_fl + 1) % MOD;
      m_halt = m_halt ? !go : m_exit;
    end
    #1;
  endtask

  function automatic logic [12:0] exp_st();
    return {m_halt, 4'(m_cyc), 4'(m_stl), 4'(m_fl)};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out: got %b exp 0000",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %h exp 0",
               {halted, cycle_cnt, stall_cnt, flush_cnt});
    end
  endtask

  task automatic load_use_setup();
    ex_mem_to_reg = 1; ex_rd = 5; ex_reg_write = 1;
    id_rs = 5; id_uses_rs = 1;
  endtask

  task automatic test_load_use();
    clear_inputs();
    load_use_setup();
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101) begin
      errors++;
      $display("FAIL load_use_out: got %b exp 1101",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
      errors++;
      $display("FAIL load_use_cnt: got %h exp %h",
               {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
    end
  endtask

  task automatic test_mem_hazard();
    clear_inputs();
    mem_rd = 5; mem_reg_write = 1; id_rt = 5; id_uses_rt = 1;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== exp_o) begin
      errors++;
      $display("FAIL mem_haz_out: got %b exp %b",
               {pc_stall, ifid_stall, ifid_flush, idex_flush}, exp_o);
    end
    tick();
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    load_use_setup();
    ex_rd = 0; id_rs = 0;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
      errors++;
      $display("FAIL reg_zero_out: got %b exp 0000",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
      errors++;
      $display("FAIL reg_zero_cnt: got %h exp %h",
               {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
    end
  endtask

  task automatic test_branch_over_hazard();
    clear_inputs();
    load_use_setup();
    ex_branch_taken = 1;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0011) begin
      errors++;
      $display("FAIL branch_out: got %b exp 0011",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
      errors++;
      $display("FAIL branch_cnt: got %h exp %h",
               {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
    end
  endtask

  task automatic test_exit_syscall();
    logic [CW-1:0] frozen;
    clear_inputs();
    ex_syscall = 1; ex_v0 = 32'd4;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
      errors++;
      $display("FAIL sys_other_out: got %b exp 0000",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL sys_other_halt: got %b exp 0", halted);
    end
    ex_v0 = 32'd10;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1011) begin
      errors++;
      $display("FAIL sys_exit_out: got %b exp 1011",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    clear_inputs();
    frozen = 4'(m_cyc);
    tick();
    tick();
    settle();
    checks++;
    if ({halted, cycle_cnt} !== {1'b1, frozen}) begin
      errors++;
      $display("FAIL halt_frozen: got %b/%0d exp 1/%0d",
               halted, cycle_cnt, frozen);
    end
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101) begin
      errors++;
      $display("FAIL halt_out: got %b exp 1101",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    go = 1;
    tick();
    go = 0;
    tick();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
      errors++;
      $display("FAIL resume: got %h exp %h",
               {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
    end
  endtask

  task automatic test_jump_vs_stall();
    clear_inputs();
    load_use_setup();
    id_jump = 1;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b1101) begin
      errors++;
      $display("FAIL jump_stall_out: got %b exp 1101",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    clear_inputs();
    id_jump = 1;
    settle();
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL jump_out: got %b exp 0010",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
    tick();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
      errors++;
      $display("FAIL jump_cnt: got %h exp %h",
               {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
    end
  endtask

  task automatic test_reset_mid_halt();
    clear_inputs();
    ex_syscall = 1; ex_v0 = 32'd10;
    tick();
    clear_inputs();
    tick();
    rst = 1;
    tick();
    rst = 0;
    settle();
    checks++;
    if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== 13'd0) begin
      errors++;
      $display("FAIL rst_halt_state: got %h exp 0",
               {halted, cycle_cnt, stall_cnt, flush_cnt});
    end
    checks++;
    if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_halt_out: got %b exp 0000",
               {pc_stall, ifid_stall, ifid_flush, idex_flush});
    end
  endtask

  task automatic test_wrap();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (cycle_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_15: got %0d exp 15", cycle_cnt);
    end
    tick();
    checks++;
    if (cycle_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wrap_0: got %0d exp 0", cycle_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      ex_reg_write = 1'($urandom);
      ex_mem_to_reg = 1'($urandom);
      mem_reg_write = 1'($urandom);
      id_jump = ($urandom_range(0, 4) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_syscall = ($urandom_range(0, 11) == 0);
      ex_v0 = $urandom_range(0, 1) ? 32'd10 : 32'($urandom_range(0, 12));
      go = ($urandom_range(0, 2) == 0);
      settle();
      checks++;
      if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== exp_o) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %b exp %b", i,
                 {pc_stall, ifid_stall, ifid_flush, idex_flush}, exp_o);
      end
      tick();
      checks++;
      if ({halted, cycle_cnt, stall_cnt, flush_cnt} !== exp_st()) begin
        errors++;
        $display("FAIL rand_state[%0d]: got %h exp %h", i,
                 {halted, cycle_cnt, stall_cnt, flush_cnt}, exp_st());
      end
    end
  endtask

  initial begin
    m_halt = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mem_hazard();
    test_reg_zero();
    test_branch_over_hazard();
    test_exit_syscall();
    test_jump_vs_stall();
    test_reset_mid_halt();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
